cdf_top: RTL and testbench

- Stage directly upstream of the divider in the histogram-equalization pipeline.
- Reads the 256-bin pixel histogram from scratch memory, packed four 32-bit bins per 128-bit word.
- Writes the cumulative distribution function (CDF) back to scratch memory in the same packing.
- Reports cdf_min, the first non-zero CDF value, which the divider consumes.

---
 rtl/cdf_top.sv | 199 +++++++++++++++++++
 tb/tb_cdf_top.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cdf_top.sv
// cdf_top: reads a 256-bin histogram (four 32-bit bins per 128-bit word) from
// scratch memory, writes the running-sum CDF back in the same packing, and
// reports cdf_min, the first non-zero CDF value, for the downstream divider.
module cdf_top #(
  parameter int unsigned NUM_WORDS = 64,
  parameter logic [15:0] RD_BASE   = 16'h0000,
  parameter logic [15:0] WT_BASE   = 16'h0040
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [127:0] cdf_sc_mem_rd_data,
  output logic [15:0]  cdf_sc_mem_rd_addr,
  output logic         cdf_sc_mem_rd_en,
  output logic [127:0] cdf_sc_mem_wt_data,
  output logic [15:0]  cdf_sc_mem_wt_addr,
  output logic         cdf_sc_mem_wt_en,
  output logic [31:0]  cdf_min,
  output logic         cdf_done
);

  localparam int unsigned    CW       = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]      wt_cnt_q, wt_cnt_d;
  logic               min_found_q, min_found_d;
  logic [15:0]        rd_addr_q, rd_addr_d;
  logic               rd_en_q, rd_en_d;
  logic [127:0]       wt_data_q, wt_data_d;
  logic [15:0]        wt_addr_q, wt_addr_d;
  logic               wt_en_q, wt_en_d;
  logic [31:0]        cdf_min_q, cdf_min_d;
  logic               done_q, done_d;

  logic [3:0][31:0]   cum_s;
  logic               min_hit_s;
  logic [31:0]        min_val_s;

  // Lane prefix sums on the incoming word, chained from the running accumulator (mod 2^32).
  always_comb begin
    cum_s[0] = acc_q    + cdf_sc_mem_rd_data[31:0];
    cum_s[1] = cum_s[0] + cdf_sc_mem_rd_data[63:32];
    cum_s[2] = cum_s[1] + cdf_sc_mem_rd_data[95:64];
    cum_s[3] = cum_s[2] + cdf_sc_mem_rd_data[127:96];
  end

  // Lowest lane (in bin order) with a non-zero cumulative value.
  always_comb begin
    min_hit_s = 1'b0;
    min_val_s = 32'd0;
    if (cum_s[0] != 32'd0) begin
      min_hit_s = 1'b1;
      min_val_s = cum_s[0];
    end else if (cum_s[1] != 32'd0) begin
      min_hit_s = 1'b1;
      min_val_s = cum_s[1];
    end else if (cum_s[2] != 32'd0) begin
      min_hit_s = 1'b1;
      min_val_s = cum_s[2];
    end else if (cum_s[3] != 32'd0) begin
      min_hit_s = 1'b1;
      min_val_s = cum_s[3];
    end else begin
      min_hit_s = 1'b0;
      min_val_s = 32'd0;
    end
  end

  // Next-state and datapath: read issue by FSM, write/accumulate one cycle behind each read.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rd_cnt_d    = rd_cnt_q;
    wt_cnt_d    = wt_cnt_q;
    min_found_d = min_found_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = 1'b0;
    wt_data_d   = wt_data_q;
    wt_addr_d   = wt_addr_q;
    wt_en_d     = 1'b0;
    cdf_min_d   = cdf_min_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        // cdf_min stays visible to the divider until the next start clears it.
        acc_d       = 32'd0;
        rd_cnt_d    = '0;
        wt_cnt_d    = '0;
        min_found_d = 1'b0;
        done_d      = 1'b0;
        if (enable) begin
          state_d   = RUN;
          rd_en_d   = 1'b1;
          rd_addr_d = RD_BASE;
          rd_cnt_d  = CW'(1);
          cdf_min_d = 32'd0;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        if (rd_cnt_q < CNT_LAST) begin
          rd_en_d   = 1'b1;
          rd_addr_d = RD_BASE + 16'(rd_cnt_q);
          rd_cnt_d  = rd_cnt_q + CW'(1);
        end else begin
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        // The last word was sampled on the edge that entered DRAIN.
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        if (!enable) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase

    // A read strobe last cycle means its data is on the bus now.
    if (rd_en_q) begin
      acc_d     = cum_s[3];
      wt_en_d   = 1'b1;
      wt_addr_d = WT_BASE + 16'(wt_cnt_q);
      wt_data_d = cum_s;
      wt_cnt_d  = wt_cnt_q + CW'(1);
      if (!min_found_q && min_hit_s) begin
        cdf_min_d   = min_val_s;
        min_found_d = 1'b1;
      end else begin
        cdf_min_d   = cdf_min_d;
        min_found_d = min_found_d;
      end
    end else begin
      wt_en_d = 1'b0;
    end
  end

  // State and output registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= 32'd0;
      rd_cnt_q    <= '0;
      wt_cnt_q    <= '0;
      min_found_q <= 1'b0;
      rd_addr_q   <= 16'd0;
      rd_en_q     <= 1'b0;
      wt_data_q   <= 128'd0;
      wt_addr_q   <= 16'd0;
      wt_en_q     <= 1'b0;
      cdf_min_q   <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rd_cnt_q    <= rd_cnt_d;
      wt_cnt_q    <= wt_cnt_d;
      min_found_q <= min_found_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      wt_data_q   <= wt_data_d;
      wt_addr_q   <= wt_addr_d;
      wt_en_q     <= wt_en_d;
      cdf_min_q   <= cdf_min_d;
      done_q      <= done_d;
    end
  end

  assign cdf_sc_mem_rd_addr = rd_addr_q;
  assign cdf_sc_mem_rd_en   = rd_en_q;
  assign cdf_sc_mem_wt_data = wt_data_q;
  assign cdf_sc_mem_wt_addr = wt_addr_q;
  assign cdf_sc_mem_wt_en   = wt_en_q;
  assign cdf_min            = cdf_min_q;
  assign cdf_done           = done_q;

endmodule

// File: tb/tb_cdf_top.sv
// tb_cdf_top: table-driven and randomized checks of cdf_top against a
// running-sum reference model of the histogram.
module tb_cdf_top;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [127:0] rd_data;
  logic [15:0]  rd_addr;
  logic         rd_en;
  logic [127:0] wt_data;
  logic [15:0]  wt_addr;
  logic         wt_en;
  logic [31:0]  cdf_min;
  logic         cdf_done;

  int errors = 0;
  int checks = 0;

  logic [31:0]  hist [256];
  logic [127:0] exp_word [64];
  logic [31:0]  exp_min;
  logic [127:0] dut_words [64];

  typedef struct {
    int           kind;       // 0 uniform, 1 spike, 2 zero, 3 wrap, 4 random
    int           drop_j;     // cycle after E0 where enable drops, -1 = hold high past done
    bit           has_const;
    logic [127:0] w0;
    logic [31:0]  w63_l3;
    logic [31:0]  mn;
  } vec_t;

  vec_t tbl [6];

  cdf_top dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .cdf_sc_mem_rd_data (rd_data),
    .cdf_sc_mem_rd_addr (rd_addr),
    .cdf_sc_mem_rd_en   (rd_en),
    .cdf_sc_mem_wt_data (wt_data),
    .cdf_sc_mem_wt_addr (wt_addr),
    .cdf_sc_mem_wt_en   (wt_en),
    .cdf_min            (cdf_min),
    .cdf_done           (cdf_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratch memory read port: word at the strobed address, filler otherwise.
  always_comb begin
    rd_data = {4{32'hA5A5_5A5A}};
    if (rd_en && rd_addr < 16'd64) begin
      for (int l = 0; l < 4; l++) rd_data[32*l +: 32] = hist[int'(rd_addr) * 4 + l];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain running sum over the 256 bins.
  task automatic build_model();
    logic [31:0] run;
    logic [31:0] cdf [256];
    bit found;
    run = 32'd0;
    found = 1'b0;
    exp_min = 32'd0;
    for (int i = 0; i < 256; i++) begin
      run = run + hist[i];
      cdf[i] = run;
      if (!found && run != 32'd0) begin
        exp_min = run;
        found = 1'b1;
      end
    end
    for (int k = 0; k < 64; k++)
      exp_word[k] = {cdf[4*k+3], cdf[4*k+2], cdf[4*k+1], cdf[4*k]};
  endtask

  task automatic load_pattern(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0: hist[i] = 32'd1;
        1: hist[i] = (i < 3) ? 32'd0 : ((i == 3) ? 32'd5 : 32'h961);
        3: hist[i] = (i == 0) ? 32'hFFFF_FFFF : ((i == 1) ? 32'd2 : 32'd0);
        4: begin
          case ($urandom_range(0, 3))
            0: hist[i] = 32'd0;
            1: hist[i] = 32'($urandom_range(0, 1000));
            2: hist[i] = $urandom;
            default: hist[i] = 32'd0;
          endcase
          if (i < 12 && $urandom_range(0, 1) == 1) hist[i] = 32'd0;
        end
        default: hist[i] = 32'd0;
      endcase
    end
    build_model();
  endtask

  // One full pass; j counts edges after E0, outputs sampled at the following negedge.
  task automatic run_pass(input int drop_j);
    int jmax;
    jmax = (drop_j >= 0) ? 66 : 70;
    @(negedge clk);
    enable = 1'b1;
    for (int j = 0; j <= jmax; j++) begin
      @(negedge clk);
      chk($sformatf("rd_en j=%0d", j), 128'(rd_en), 128'(j <= 63));
      if (j <= 63) chk($sformatf("rd_addr j=%0d", j), 128'(rd_addr), 128'(j));
      chk($sformatf("wt_en j=%0d", j), 128'(wt_en), 128'(j >= 1 && j <= 64));
      if (j >= 1 && j <= 64) begin
        dut_words[j-1] = wt_data;
        chk($sformatf("wt_addr j=%0d", j), 128'(wt_addr), 128'(16'h0040 + 16'(j - 1)));
        chk($sformatf("wt_data j=%0d", j), wt_data, exp_word[j-1]);
      end
      if (j >= 65) begin
        chk($sformatf("wt_addr_hold j=%0d", j), 128'(wt_addr), 128'(16'h007F));
        chk($sformatf("wt_data_hold j=%0d", j), wt_data, exp_word[63]);
        chk($sformatf("cdf_min j=%0d", j), 128'(cdf_min), 128'(exp_min));
      end
      chk($sformatf("done j=%0d", j), 128'(cdf_done),
          128'(j >= 65 && !(drop_j >= 0 && j >= 66)));
      if (j == drop_j) enable = 1'b0;
    end
    if (drop_j < 0) begin
      enable = 1'b0;
      @(negedge clk);
      chk("done_clear", 128'(cdf_done), 128'(1'b0));
      chk("no_restart_rd", 128'(rd_en), 128'(1'b0));
    end
  endtask

  initial begin
    tbl[0] = '{kind: 0, drop_j: -1, has_const: 1'b1,
               w0: 128'h00000004_00000003_00000002_00000001, w63_l3: 32'd256, mn: 32'd1};
    tbl[1] = '{kind: 1, drop_j: 10, has_const: 1'b1,
               w0: 128'h00000005_00000000_00000000_00000000, w63_l3: 32'd605057, mn: 32'd5};
    tbl[2] = '{kind: 2, drop_j: -1, has_const: 1'b1,
               w0: 128'd0, w63_l3: 32'd0, mn: 32'd0};
    tbl[3] = '{kind: 3, drop_j: 64, has_const: 1'b1,
               w0: 128'h00000001_00000001_00000001_FFFFFFFF, w63_l3: 32'd1, mn: 32'hFFFF_FFFF};
    tbl[4] = '{kind: 4, drop_j: -1, has_const: 1'b0, w0: 128'd0, w63_l3: 32'd0, mn: 32'd0};
    tbl[5] = '{kind: 4, drop_j: 30, has_const: 1'b0, w0: 128'd0, w63_l3: 32'd0, mn: 32'd0};

    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 256; i++) hist[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst rd_en", 128'(rd_en), 128'd0);
    chk("rst wt_en", 128'(wt_en), 128'd0);
    chk("rst wt_data", wt_data, 128'd0);
    chk("rst cdf_min", 128'(cdf_min), 128'd0);
    chk("rst done", 128'(cdf_done), 128'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      load_pattern(tbl[t].kind);
      run_pass(tbl[t].drop_j);
      if (tbl[t].has_const) begin
        chk($sformatf("t%0d word0", t), dut_words[0], tbl[t].w0);
        chk($sformatf("t%0d word63 lane3", t), 128'(dut_words[63][127:96]), 128'(tbl[t].w63_l3));
        chk($sformatf("t%0d cdf_min const", t), 128'(exp_min), 128'(tbl[t].mn));
      end
      repeat (2) @(negedge clk);
    end

    // Abort mid-pass with reset while word 20 is being written.
    load_pattern(4);
    @(negedge clk);
    enable = 1'b1;
    for (int j = 0; j <= 21; j++) @(negedge clk);
    chk("abort pre wt_addr", 128'(wt_addr), 128'(16'h0054));
    #2 reset = 1'b0;
    #1;
    chk("abort rd_en", 128'(rd_en), 128'd0);
    chk("abort wt_en", 128'(wt_en), 128'd0);
    chk("abort rd_addr", 128'(rd_addr), 128'd0);
    chk("abort wt_addr", 128'(wt_addr), 128'd0);
    chk("abort wt_data", wt_data, 128'd0);
    chk("abort cdf_min", 128'(cdf_min), 128'd0);
    chk("abort done", 128'(cdf_done), 128'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle rd_en", 128'(rd_en), 128'd0);
    chk("idle wt_en", 128'(wt_en), 128'd0);

    load_pattern(4);
    run_pass(-1);
    load_pattern(0);
    run_pass(-1);
    chk("post-abort word0", dut_words[0], 128'h00000004_00000003_00000002_00000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
